// File: rtl/store_pkg.sv
// Shared encodings for the RV32I store path: AHB-Lite codes, store sizes, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package store_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_ERR  = 2'b11
    } state_e;

    // Store-size code to AHB HSIZE; the reserved code 11 is treated as a word.
    function automatic logic [2:0] size_to_hsize(input logic [1:0] sz);
        logic [2:0] hs;
        case (sz)
            SZ_BYTE: hs = HSIZE_BYTE;
            SZ_HALF: hs = HSIZE_HALF;
            default: hs = HSIZE_WORD;
        endcase
        return hs;
    endfunction

endpackage

// File: rtl/store_align.sv
// Lane aligner: replicates store data onto byte lanes, builds strobes, flags misalignment.
// Latency: combinational, zero cycles.
// Backpressure: none; purely a function of its inputs.
module store_align
    import store_pkg::*;
(
    input  logic [31:0] rs2_in,
    input  logic [1:0]  addr_lo_in,
    input  logic [1:0]  size_in,
    output logic [31:0] lane_dat_out,
    output logic [3:0]  mask_out,
    output logic        misaligned_out
);

    // Replicate the narrow datum across all lanes so the strobe alone selects the target bytes.
    always_comb begin
        lane_dat_out   = rs2_in;
        mask_out       = 4'b1111;
        misaligned_out = (addr_lo_in != 2'b00);
        case (size_in)
            SZ_BYTE: begin
                lane_dat_out   = {4{rs2_in[7:0]}};
                mask_out       = 4'b0001 << addr_lo_in;
                misaligned_out = 1'b0;
            end
            SZ_HALF: begin
                lane_dat_out   = {2{rs2_in[15:0]}};
                mask_out       = addr_lo_in[1] ? 4'b1100 : 4'b0011;
                misaligned_out = addr_lo_in[0];
            end
            default: begin
                lane_dat_out   = rs2_in;
                mask_out       = 4'b1111;
                misaligned_out = (addr_lo_in != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// RV32I store unit: one aligned AHB-Lite write per request, reports done/misaligned/bus error.
// Latency: zero-wait store accepted at T gives address phase T+1, data phase T+2, done pulse T+3.
// Backpressure: st_ready_out is high only in IDLE; AHB wait states stretch ADDR/DATA/ERR.
module store_unit
    import store_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              st_valid_in,
    output logic              st_ready_out,
    input  logic [DATA_W-1:0] rs2_in,
    input  logic [ADDR_W-1:0] iadder_in,
    input  logic [1:0]        store_size_in,
    output logic [3:0]        wr_mask_out,
    output logic [ADDR_W-1:0] haddr_out,
    output logic [1:0]        htrans_out,
    output logic              hwrite_out,
    output logic [2:0]        hsize_out,
    output logic [DATA_W-1:0] hwdata_out,
    input  logic              hready_in,
    input  logic              hresp_in,
    output logic              st_done_out,
    output logic              misaligned_out,
    output logic              bus_err_out
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic [2:0]        hsize_q, hsize_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic [3:0]        mask_q, mask_d;
    logic              done_q, done_d;
    logic              mis_q, mis_d;
    logic              berr_q, berr_d;

    logic [31:0]       aln_dat;
    logic [3:0]        aln_mask;
    logic              aln_mis;
    logic              accept_vld;

    store_align u_align (
        .rs2_in         (rs2_in),
        .addr_lo_in     (iadder_in[1:0]),
        .size_in        (store_size_in),
        .lane_dat_out   (aln_dat),
        .mask_out       (aln_mask),
        .misaligned_out (aln_mis)
    );

    assign st_ready_out   = (state_q == ST_IDLE);
    assign accept_vld     = st_valid_in & st_ready_out;
    assign haddr_out      = haddr_q;
    assign hsize_out      = hsize_q;
    assign hwdata_out     = hwdata_q;
    assign st_done_out    = done_q;
    assign misaligned_out = mis_q;
    assign bus_err_out    = berr_q;

    // Next-state, request capture and AHB control decode; status pulses default low each cycle.
    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        hsize_d     = hsize_q;
        hwdata_d    = hwdata_q;
        mask_d      = mask_q;
        done_d      = 1'b0;
        mis_d       = 1'b0;
        berr_d      = 1'b0;
        htrans_out  = HTRANS_IDLE;
        hwrite_out  = 1'b0;
        wr_mask_out = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (accept_vld) begin
                    if (aln_mis) begin
                        // Misaligned requests never reach the bus; only the status pulse.
                        mis_d = 1'b1;
                    end else begin
                        state_d  = ST_ADDR;
                        haddr_d  = iadder_in;
                        hsize_d  = size_to_hsize(store_size_in);
                        hwdata_d = aln_dat;
                        mask_d   = aln_mask;
                    end
                end
            end
            ST_ADDR: begin
                htrans_out  = HTRANS_NONSEQ;
                hwrite_out  = 1'b1;
                wr_mask_out = mask_q;
                if (hready_in) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                wr_mask_out = mask_q;
                if (hresp_in) begin
                    // A one-cycle error (hready already high) is still reported as a bus error.
                    if (hready_in) begin
                        berr_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else if (hready_in) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                wr_mask_out = mask_q;
                if (hready_in) begin
                    berr_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request registers; reset abandons any transfer in flight.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q  <= ST_IDLE;
            haddr_q  <= '0;
            hsize_q  <= '0;
            hwdata_q <= '0;
            mask_q   <= '0;
            done_q   <= 1'b0;
            mis_q    <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            hsize_q  <= hsize_d;
            hwdata_q <= hwdata_d;
            mask_q   <= mask_d;
            done_q   <= done_d;
            mis_q    <= mis_d;
            berr_q   <= berr_d;
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed scenarios plus randomized stores against a lane model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: bench drives hready/hresp wait and error patterns.
module tb_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] rs2 = '0;
    logic [31:0] iadder = '0;
    logic [1:0]  st_size = '0;
    logic [3:0]  wr_mask;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;
    logic        st_done;
    logic        misaligned;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_in         (clk),
        .reset_in       (reset),
        .st_valid_in    (st_valid),
        .st_ready_out   (st_ready),
        .rs2_in         (rs2),
        .iadder_in      (iadder),
        .store_size_in  (st_size),
        .wr_mask_out    (wr_mask),
        .haddr_out      (haddr),
        .htrans_out     (htrans),
        .hwrite_out     (hwrite),
        .hsize_out      (hsize),
        .hwdata_out     (hwdata),
        .hready_in      (hready),
        .hresp_in       (hresp),
        .st_done_out    (st_done),
        .misaligned_out (misaligned),
        .bus_err_out    (bus_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: an n-byte store occupies lanes off..off+n-1, each lane carries byte (lane mod n) of rs2.
    function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                                  output logic mis, output logic [31:0] dat, output logic [3:0] msk,
                                  output logic [2:0] hs);
        int n;
        int off;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(a[1:0]);
        mis = (off % n) != 0;
        dat = '0;
        msk = '0;
        for (int i = 0; i < 4; i++) begin
            dat[8*i +: 8] = d[8*(i % n) +: 8];
            if (i >= off && i < off + n) msk[i] = 1'b1;
        end
        hs = (n == 1) ? 3'b000 : (n == 2) ? 3'b001 : 3'b010;
    endfunction

    task automatic start_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        iadder = a; rs2 = d; st_size = sz; st_valid = 1'b1; hready = 1'b1; hresp = 1'b0;
        tick();
        st_valid = 1'b0; iadder = $urandom; rs2 = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        n_checks++; if (htrans !== 2'b00) begin n_fail++; $display("FAIL rst_htrans: got %b want 00", htrans); end
        n_checks++; if (hwrite !== 1'b0) begin n_fail++; $display("FAIL rst_hwrite: got %b want 0", hwrite); end
        n_checks++; if (haddr !== 32'h0) begin n_fail++; $display("FAIL rst_haddr: got %h want 0", haddr); end
        n_checks++; if (hsize !== 3'b000) begin n_fail++; $display("FAIL rst_hsize: got %b want 000", hsize); end
        n_checks++; if (hwdata !== 32'h0) begin n_fail++; $display("FAIL rst_hwdata: got %h want 0", hwdata); end
        n_checks++; if (wr_mask !== 4'b0000) begin n_fail++; $display("FAIL rst_mask: got %b want 0000", wr_mask); end
        n_checks++; if ({st_done, misaligned, bus_err} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses: got %b want 000", {st_done, misaligned, bus_err}); end
        n_checks++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", st_ready); end
    endtask

    task automatic test_word();
        start_store(32'h100, 32'hDEADBEEF, 2'b10);
        n_checks++; if (htrans !== 2'b10) begin n_fail++; $display("FAIL word_htrans: got %b want 10", htrans); end
        n_checks++; if (haddr !== 32'h100) begin n_fail++; $display("FAIL word_haddr: got %h want 100", haddr); end
        n_checks++; if (hsize !== 3'b010) begin n_fail++; $display("FAIL word_hsize: got %b want 010", hsize); end
        n_checks++; if (hwrite !== 1'b1) begin n_fail++; $display("FAIL word_hwrite: got %b want 1", hwrite); end
        n_checks++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL word_busy: got %b want 0", st_ready); end
        tick();
        n_checks++; if (hwdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_hwdata: got %h want deadbeef", hwdata); end
        n_checks++; if (wr_mask !== 4'b1111) begin n_fail++; $display("FAIL word_mask: got %b want 1111", wr_mask); end
        n_checks++; if (htrans !== 2'b00) begin n_fail++; $display("FAIL word_dphase_htrans: got %b want 00", htrans); end
        n_checks++; if (st_done !== 1'b0) begin n_fail++; $display("FAIL word_early_done: got %b want 0", st_done); end
        tick();
        n_checks++; if (st_done !== 1'b1) begin n_fail++; $display("FAIL word_done: got %b want 1", st_done); end
        n_checks++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL word_ready: got %b want 1", st_ready); end
        n_checks++; if (wr_mask !== 4'b0000) begin n_fail++; $display("FAIL word_mask_idle: got %b want 0000", wr_mask); end
        tick();
        n_checks++; if (st_done !== 1'b0) begin n_fail++; $display("FAIL word_done_width: got %b want 0", st_done); end
    endtask

    task automatic test_byte();
        start_store(32'h203, 32'h000000A5, 2'b00);
        n_checks++; if (haddr !== 32'h203) begin n_fail++; $display("FAIL byte_haddr: got %h want 203", haddr); end
        n_checks++; if (hsize !== 3'b000) begin n_fail++; $display("FAIL byte_hsize: got %b want 000", hsize); end
        tick();
        n_checks++; if (hwdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL byte_hwdata: got %h want a5a5a5a5", hwdata); end
        n_checks++; if (wr_mask !== 4'b1000) begin n_fail++; $display("FAIL byte_mask: got %b want 1000", wr_mask); end
        tick();
        n_checks++; if (st_done !== 1'b1) begin n_fail++; $display("FAIL byte_done: got %b want 1", st_done); end
        tick();
    endtask

    task automatic test_half_wait();
        start_store(32'h302, 32'h1234ABCD, 2'b01);
        for (int c = 0; c < 3; c++) begin
            hready = (c == 2);
            n_checks++; if ({htrans, haddr, hsize} !== {2'b10, 32'h302, 3'b001}) begin n_fail++; $display("FAIL half_addr_hold c=%0d: got %b/%h/%b want 10/302/001", c, htrans, haddr, hsize); end
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            hready = (c == 2);
            n_checks++; if ({hwdata, wr_mask} !== {32'hABCDABCD, 4'b1100}) begin n_fail++; $display("FAIL half_data_hold c=%0d: got %h/%b want abcdabcd/1100", c, hwdata, wr_mask); end
            n_checks++; if (st_done !== 1'b0) begin n_fail++; $display("FAIL half_early_done c=%0d: got %b want 0", c, st_done); end
            tick();
        end
        n_checks++; if (st_done !== 1'b1) begin n_fail++; $display("FAIL half_done: got %b want 1", st_done); end
        tick();
    endtask

    task automatic test_misaligned();
        start_store(32'h101, 32'h11223344, 2'b10);
        n_checks++; if (misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %b want 1", misaligned); end
        n_checks++; if ({htrans, st_done, st_ready} !== {2'b00, 1'b0, 1'b1}) begin n_fail++; $display("FAIL mis_nobus: got htrans=%b done=%b ready=%b want 00/0/1", htrans, st_done, st_ready); end
        tick();
        n_checks++; if ({misaligned, htrans, st_done} !== 4'b0000) begin n_fail++; $display("FAIL mis_after: got mis=%b htrans=%b done=%b want 0/00/0", misaligned, htrans, st_done); end
        start_store(32'h104, 32'hCAFEF00D, 2'b10);
        n_checks++; if ({htrans, haddr} !== {2'b10, 32'h104}) begin n_fail++; $display("FAIL mis_next_addr: got %b/%h want 10/104", htrans, haddr); end
        tick();
        n_checks++; if (hwdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mis_next_data: got %h want cafef00d", hwdata); end
        tick();
        n_checks++; if (st_done !== 1'b1) begin n_fail++; $display("FAIL mis_next_done: got %b want 1", st_done); end
        tick();
    endtask

    task automatic test_bus_err();
        start_store(32'h400, 32'h5555BEEF, 2'b01);
        tick();
        hresp = 1'b1; hready = 1'b0;
        n_checks++; if ({hwdata, wr_mask} !== {32'hBEEFBEEF, 4'b0011}) begin n_fail++; $display("FAIL err_data: got %h/%b want beefbeef/0011", hwdata, wr_mask); end
        tick();
        hready = 1'b1;
        n_checks++; if ({bus_err, st_done, htrans} !== 4'b0000) begin n_fail++; $display("FAIL err_wait: got berr=%b done=%b htrans=%b want 0/0/00", bus_err, st_done, htrans); end
        tick();
        hresp = 1'b0;
        n_checks++; if ({bus_err, st_done, st_ready} !== 3'b101) begin n_fail++; $display("FAIL err_pulse: got berr=%b done=%b ready=%b want 1/0/1", bus_err, st_done, st_ready); end
        tick();
        n_checks++; if ({bus_err, st_done} !== 2'b00) begin n_fail++; $display("FAIL err_after: got berr=%b done=%b want 0/0", bus_err, st_done); end
    endtask

    task automatic test_reset_mid();
        start_store(32'h500, 32'h0BADF00D, 2'b10);
        tick();
        hready = 1'b0;
        n_checks++; if (wr_mask !== 4'b1111) begin n_fail++; $display("FAIL rmid_mask: got %b want 1111", wr_mask); end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; hready = 1'b1;
        n_checks++; if ({htrans, wr_mask} !== 6'b000000) begin n_fail++; $display("FAIL rmid_bus: got htrans=%b mask=%b want 00/0000", htrans, wr_mask); end
        n_checks++; if ({st_done, misaligned, bus_err, st_ready} !== 4'b0001) begin n_fail++; $display("FAIL rmid_status: got %b want 0001", {st_done, misaligned, bus_err, st_ready}); end
        tick();
        n_checks++; if (st_done !== 1'b0) begin n_fail++; $display("FAIL rmid_nodone: got %b want 0", st_done); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 80; it++) begin
            logic [31:0] a, d, edat;
            logic [1:0]  sz;
            logic [3:0]  emsk;
            logic [2:0]  ehs;
            logic        emis, err;
            int          aw, dw, ew;
            a = $urandom; d = $urandom; sz = 2'($urandom_range(0, 3));
            aw = $urandom_range(0, 2); dw = $urandom_range(0, 2); ew = $urandom_range(0, 2);
            err = ($urandom_range(0, 3) == 0);
            model(a, d, sz, emis, edat, emsk, ehs);
            start_store(a, d, sz);
            if (emis) begin
                n_checks++; if ({misaligned, htrans, st_done, st_ready} !== 5'b10001) begin n_fail++; $display("FAIL rnd_mis it=%0d a=%h sz=%0d: got mis=%b htrans=%b done=%b ready=%b", it, a, sz, misaligned, htrans, st_done, st_ready); end
            end else begin
                for (int c = 0; c <= aw; c++) begin
                    hready = (c == aw);
                    n_checks++; if ({htrans, hwrite, haddr, hsize} !== {2'b10, 1'b1, a, ehs}) begin n_fail++; $display("FAIL rnd_addr it=%0d: got %b/%b/%h/%b want 10/1/%h/%b", it, htrans, hwrite, haddr, hsize, a, ehs); end
                    tick();
                end
                for (int c = 0; c < (err ? dw + 1 : dw + 1); c++) begin
                    hready = (!err && c == dw);
                    hresp  = (err && c == dw);
                    n_checks++; if ({htrans, hwdata, wr_mask, st_done} !== {2'b00, edat, emsk, 1'b0}) begin n_fail++; $display("FAIL rnd_data it=%0d a=%h sz=%0d: got %b/%h/%b/%b want 00/%h/%b/0", it, a, sz, htrans, hwdata, wr_mask, st_done, edat, emsk); end
                    tick();
                end
                if (err) begin
                    for (int c = 0; c <= ew; c++) begin
                        hready = (c == ew); hresp = 1'b1;
                        n_checks++; if ({bus_err, st_done, htrans, hwdata} !== {4'b0000, edat}) begin n_fail++; $display("FAIL rnd_errwait it=%0d: got berr=%b done=%b htrans=%b data=%h", it, bus_err, st_done, htrans, hwdata); end
                        tick();
                    end
                end
                hready = 1'b1; hresp = 1'b0;
                n_checks++; if ({st_done, bus_err, st_ready, wr_mask} !== {~err, err, 1'b1, 4'b0000}) begin n_fail++; $display("FAIL rnd_end it=%0d err=%b: got done=%b berr=%b ready=%b mask=%b", it, err, st_done, bus_err, st_ready, wr_mask); end
                n_checks++; if (hwdata !== edat) begin n_fail++; $display("FAIL rnd_hold it=%0d: got %h want %h", it, hwdata, edat); end
            end
            tick();
            n_checks++; if ({st_done, misaligned, bus_err} !== 3'b000) begin n_fail++; $display("FAIL rnd_pulse_width it=%0d: got %b want 000", it, {st_done, misaligned, bus_err}); end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half_wait();
        test_misaligned();
        test_bus_err();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
